// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Runs loads/stores on a req/ack data-memory bus, stalls the front of the
// pipeline while a transaction is outstanding, and registers the selected
// write-back value into the MEM/WB boundary.
// Optional feature: define MEM_TIMEOUT_EN to abort transactions that wait
// TIMEOUT_CYCLES cycles in WAIT without an ack (reported on mem_err).
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Regfile_weM,
  input  logic        DataMem_weM,
  input  logic [4:0]  writeRegAddrM,
  input  logic [1:0]  regSrc_muxM,
  input  logic [31:0] aluOutM,
  input  logic [31:0] writeDataM,
  input  logic [31:0] jal_targetM,
  input  logic [31:0] pcM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic        Regfile_weW,
  output logic [4:0]  writeRegAddrW,
  output logic [31:0] writeBackDataW,
  output logic [31:0] jal_targetW,
  output logic        mem_err
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        is_load;
  logic        mem_op;
  logic        abort;
  logic [31:0] wb_data;

  assign is_load = (regSrc_muxM == 2'b01) && Regfile_weM;
  assign mem_op  = is_load || DataMem_weM;

  // The EX/MEM register is frozen while stallM is high, so driving the bus
  // straight from the M-stage fields keeps address/data/strobe stable in WAIT.
  // A load that is also flagged as a store goes out as a store.
  assign dmem_we    = DataMem_weM;
  assign dmem_addr  = {aluOutM[31:2], 2'b00};
  assign dmem_wdata = writeDataM;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wait_cnt;

  // An ack in the timeout cycle wins over the abort.
  assign abort = (state == ST_WAIT) && mem_op && !dmem_ack &&
                 (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter: zero on entry to WAIT, counts WAIT cycles without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= '0;
    end else if (!dmem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // One-cycle abort pulse towards the exception/trace logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_err <= 1'b0;
    else      mem_err <= abort;
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign mem_err        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // State register; an outstanding transaction is simply dropped on reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic plus the combinational request and stall.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    dmem_req   = 1'b0;
    stallM     = 1'b0;

    if (mem_op) begin
      dmem_req = rst && !abort;
      stallM   = !dmem_ack && !abort;
    end

    unique case (state)
      ST_IDLE: if (mem_op && !dmem_ack) state_next = ST_WAIT;
      ST_WAIT: if (!mem_op || dmem_ack || abort) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Write-back source select; pcM+4 wraps naturally at 32 bits.
  always_comb begin
    unique case (regSrc_muxM)
      2'b01:   wb_data = dmem_rdata;
      2'b10:   wb_data = pcM + 32'd4;
      default: wb_data = aluOutM;
    endcase
  end

  // MEM/WB register: a stalled or aborted edge writes a bubble
  // (write enable low) so each instruction writes the register file once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Regfile_weW    <= 1'b0;
      writeRegAddrW  <= '0;
      writeBackDataW <= '0;
      jal_targetW    <= '0;
    end else begin
      Regfile_weW <= Regfile_weM && !stallM && !abort;
      if (!stallM) begin
        writeRegAddrW  <= writeRegAddrM;
        writeBackDataW <= wb_data;
        jal_targetW    <= jal_targetM;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Fixed vector table, hand sequences for multi-cycle corners, then randomized
// instructions against a behavioural model. Timeout checks compile only when
// MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        Regfile_weM;
  logic        DataMem_weM;
  logic [4:0]  writeRegAddrM;
  logic [1:0]  regSrc_muxM;
  logic [31:0] aluOutM;
  logic [31:0] writeDataM;
  logic [31:0] jal_targetM;
  logic [31:0] pcM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stallM;
  logic        Regfile_weW;
  logic [4:0]  writeRegAddrW;
  logic [31:0] writeBackDataW;
  logic [31:0] jal_targetW;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .Regfile_weM    (Regfile_weM),
    .DataMem_weM    (DataMem_weM),
    .writeRegAddrM  (writeRegAddrM),
    .regSrc_muxM    (regSrc_muxM),
    .aluOutM        (aluOutM),
    .writeDataM     (writeDataM),
    .jal_targetM    (jal_targetM),
    .pcM            (pcM),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .stallM         (stallM),
    .Regfile_weW    (Regfile_weW),
    .writeRegAddrW  (writeRegAddrW),
    .writeBackDataW (writeBackDataW),
    .jal_targetW    (jal_targetW),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction: M-stage fields, memory response, and expectations.
  typedef struct {
    logic        we;
    logic        dwe;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] jal;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          n_wait;
    logic        exp_req;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the stage's rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_req = ((v.src == 2'b01) && v.we) || v.dwe;
    case (v.src)
      2'b01:   r.exp_data = v.rdata;
      2'b10:   r.exp_data = v.pc + 32'd4;
      default: r.exp_data = v.alu;
    endcase
    return r;
  endfunction

  task automatic drive_fields(input vec_t v);
    Regfile_weM   = v.we;
    DataMem_weM   = v.dwe;
    writeRegAddrM = v.rd;
    regSrc_muxM   = v.src;
    aluOutM       = v.alu;
    writeDataM    = v.wdata;
    jal_targetM   = v.jal;
    pcM           = v.pc;
  endtask

  // Called just after a rising edge; returns just after the edge that
  // retires the instruction into W.
  task automatic run_op(input vec_t v);
    int n;
    n = v.exp_req ? v.n_wait : 0;
    drive_fields(v);
    for (int c = 0; c <= n; c++) begin
      // Ack on a non-memory instruction must be ignored.
      dmem_ack   = v.exp_req ? (c == n) : 1'($urandom_range(0, 1));
      dmem_rdata = (c == n) ? v.rdata : $urandom;
      @(negedge clk);
      check("dmem_req", 32'(dmem_req), 32'(v.exp_req));
      check("stallM", 32'(stallM), 32'(v.exp_req && (c < n)));
      if (v.exp_req) begin
        check("dmem_addr", dmem_addr, {v.alu[31:2], 2'b00});
        check("dmem_we", 32'(dmem_we), 32'(v.dwe));
        check("dmem_wdata", dmem_wdata, v.wdata);
      end
      @(posedge clk);
      #1;
      if (c < n) check("bubble_weW", 32'(Regfile_weW), 32'd0);
    end
    dmem_ack = 1'b0;
    check("Regfile_weW", 32'(Regfile_weW), 32'(v.we));
    check("writeRegAddrW", 32'(writeRegAddrW), 32'(v.rd));
    check("writeBackDataW", writeBackDataW, v.exp_data);
    check("jal_targetW", jal_targetW, v.jal);
  endtask

  vec_t table_v[7];
  vec_t v;

  initial begin
    // Hand-computed zero-wait vectors:
    //  we  dwe rd  src   alu           wdata         jal           pc            rdata         nw req data
    table_v[0] = '{1'b1, 1'b0, 5'd5,  2'b00, 32'h0000_1234, 32'h0,        32'h1111_0000, 32'h0000_0100, 32'h5555_5555, 0, 1'b0, 32'h0000_1234};
    table_v[1] = '{1'b1, 1'b0, 5'd7,  2'b01, 32'h0000_0103, 32'h0,        32'h2222_0000, 32'h0000_0104, 32'hCAFE_F00D, 0, 1'b1, 32'hCAFE_F00D};
    table_v[2] = '{1'b1, 1'b0, 5'd31, 2'b10, 32'h0000_0008, 32'h0,        32'h3333_0000, 32'hFFFF_FFFC, 32'h0,         0, 1'b0, 32'h0000_0000};
    table_v[3] = '{1'b1, 1'b0, 5'd1,  2'b11, 32'hDEAD_BEEF, 32'h0,        32'h4444_0000, 32'h0000_0200, 32'h0,         0, 1'b0, 32'hDEAD_BEEF};
    table_v[4] = '{1'b0, 1'b0, 5'd2,  2'b01, 32'h0000_0040, 32'h0,        32'h5555_0000, 32'h0000_0300, 32'hA5A5_0001, 0, 1'b0, 32'hA5A5_0001};
    table_v[5] = '{1'b1, 1'b1, 5'd9,  2'b01, 32'h0000_0ABE, 32'h7777_8888, 32'h6666_0000, 32'h0000_0400, 32'h0BAD_C0DE, 0, 1'b1, 32'h0BAD_C0DE};
    table_v[6] = '{1'b0, 1'b1, 5'd3,  2'b00, 32'h8000_0007, 32'h1357_9BDF, 32'h7777_0000, 32'h0000_0500, 32'h0,         0, 1'b1, 32'h8000_0007};

    // Reset with a load presented: request must stay low, W cleared.
    drive_fields(table_v[1]);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    rst        = 1'b0;
    #3;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_weW", 32'(Regfile_weW), 32'd0);
    check("rst_rd", 32'(writeRegAddrW), 32'd0);
    check("rst_data", writeBackDataW, 32'd0);
    check("rst_jal", jal_targetW, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    Regfile_weM = 1'b0;
    DataMem_weM = 1'b0;
    #20;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_op(table_v[i]);

    // 3-wait store, 2-wait load, then back-to-back zero-wait load.
    v = model('{1'b0, 1'b1, 5'd4, 2'b00, 32'h0000_1006, 32'hFEED_BEEF, 32'h0, 32'h0, 32'h0, 3, 1'b0, 32'h0});
    run_op(v);
    v = model('{1'b1, 1'b0, 5'd6, 2'b01, 32'h0000_2001, 32'h0, 32'h9, 32'h10, 32'h1234_5678, 2, 1'b0, 32'h0});
    run_op(v);
    v = model('{1'b1, 1'b0, 5'd8, 2'b01, 32'h0000_2005, 32'h0, 32'hA, 32'h14, 32'h8765_4321, 0, 1'b0, 32'h0});
    run_op(v);

    // Reset in the middle of a waiting load.
    drive_fields(model('{1'b1, 1'b0, 5'd10, 2'b01, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'h0}));
    dmem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midwait_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("midwait_req", 32'(dmem_req), 32'd0);
    check("midwait_weW", 32'(Regfile_weW), 32'd0);
    check("midwait_data", writeBackDataW, 32'd0);
    Regfile_weM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    v = model('{1'b1, 1'b0, 5'd11, 2'b01, 32'h0000_3004, 32'h0, 32'hB, 32'h20, 32'h0F0F_0F0F, 0, 1'b0, 32'h0});
    run_op(v);

`ifdef MEM_TIMEOUT_EN
    // Load never acked: abort in the 4th WAIT cycle.
    drive_fields(model('{1'b1, 1'b0, 5'd12, 2'b01, 32'h0000_4000, 32'h0, 32'hC, 32'h30, 32'h0, 0, 1'b0, 32'h0}));
    dmem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("to_stall", 32'(stallM), 32'd1);
      check("to_req", 32'(dmem_req), 32'd1);
      @(posedge clk);
      #1;
      check("to_err_low", 32'(mem_err), 32'd0);
    end
    @(negedge clk);
    check("to_abort_stall", 32'(stallM), 32'd0);
    check("to_abort_req", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    check("to_err", 32'(mem_err), 32'd1);
    check("to_weW", 32'(Regfile_weW), 32'd0);
    v = model('{1'b1, 1'b0, 5'd13, 2'b00, 32'h0000_0042, 32'h0, 32'hD, 32'h34, 32'h0, 0, 1'b0, 32'h0});
    run_op(v);
    check("to_err_pulse", 32'(mem_err), 32'd0);
`endif

    // Randomized instruction stream with random wait states.
    for (int i = 0; i < 200; i++) begin
      v.we     = 1'($urandom_range(0, 1));
      v.dwe    = ($urandom_range(0, 2) == 0);
      v.rd     = 5'($urandom);
      v.src    = 2'($urandom);
      v.alu    = $urandom;
      v.wdata  = $urandom;
      v.jal    = $urandom;
      v.pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
      v.rdata  = $urandom;
      v.n_wait = $urandom_range(0, 3);
      run_op(model(v));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage that sits directly downstream of the EX/MEM pipeline register. It consumes the registered M-stage control and data, runs load/store transactions on a req/ack data-memory bus, and stalls the front of the pipeline while a transaction is outstanding. It selects the write-back value and registers it into the MEM/WB boundary for the register file.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: wait cycles in WAIT before a transaction is aborted. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- Regfile_weM  in  1  register-file write enable of the M-stage instruction
- DataMem_weM  in  1  store request
- writeRegAddrM  in  5  destination register
- regSrc_muxM  in  2  write-back source: 00 ALU, 01 memory, 10 pcM+4, 11 ALU
- aluOutM  in  32  ALU result, also the memory byte address
- writeDataM  in  32  store data
- jal_targetM  in  32  jump target; passed through to W
- pcM  in  32  instruction PC
- dmem_req  out  1  memory request
- dmem_we  out  1  write strobe, valid while dmem_req=1
- dmem_addr  out  32  word address, {aluOutM[31:2],2'b00}
- dmem_wdata  out  32  equals writeDataM
- dmem_ack  in  1  transaction complete; may assert in the same cycle as dmem_req
- dmem_rdata  in  32  load data, valid while dmem_ack=1
- stallM  out  1  freezes EX/MEM and all earlier stages
- Regfile_weW  out  1  registered write enable
- writeRegAddrW  out  5  registered destination
- writeBackDataW  out  32  registered write-back value
- jal_targetW  out  32  registered pass-through
- mem_err  out  1  registered one-cycle abort pulse

## Operation
- Load: regSrc_muxM==01 and Regfile_weM==1.
- Memory op: load or DataMem_weM==1.
- If both conditions hold, the operation is treated as a store. Write-back is still taken from dmem_rdata.
- FSM states:
  - IDLE: if a memory op is present, dmem_req=1 combinationally.
    - dmem_ack=1 in the same cycle: complete, stay in IDLE.
    - No ack: go to WAIT.
  - WAIT: dmem_req=1 and dmem_addr/dmem_we/dmem_wdata are held stable. On dmem_ack: complete and go to IDLE.
- stallM = memory op present & ~dmem_ack & ~abort. It is combinational.
- Write-back selection: 00/11 aluOutM; 01 dmem_rdata; 10 pcM+4, computed modulo 2^32 (wraps at 32'hFFFFFFFC).
- W registers load {Regfile_weM, writeRegAddrM, selected data, jal_targetM} on each edge where stallM=0.
- On each edge where stallM=1, W registers load a bubble: Regfile_weW=0, other fields unchanged. This guarantees exactly one register-file write per instruction.
- Non-memory instructions never assert dmem_req.

## Timing
- Reset (asynchronous, rst=0):
  - State goes to IDLE.
  - Regfile_weW=0, writeRegAddrW=0, writeBackDataW=0, jal_targetW=0, mem_err=0.
  - dmem_req=0 while rst=0.
  - An outstanding transaction is dropped. The memory side must tolerate a request withdrawn without ack.
- Non-memory instruction: 1-cycle latency M->W, no stall.
- Zero-wait access (ack in the request cycle): 1-cycle latency, no stall.
- N-wait access: stallM high for N cycles. W is valid on the edge after the cycle where ack is seen.
- Back-to-back memory ops: the next op's request may assert in the cycle immediately after the ack cycle (state IDLE).
- dmem_ack while dmem_req=0 is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter equals TIMEOUT_CYCLES-1 with no ack:
    - abort=1, so stallM=0 and dmem_req=0 in that cycle.
    - State returns to IDLE.
    - The edge loads W with Regfile_weW=0.
    - mem_err=1 for one cycle.
  - If ack and timeout coincide, ack wins.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists until ack; mem_err is constant 0.

## Test plan
- Reset mid-WAIT: rst low while dmem_req=1 -> dmem_req=0 and Regfile_weW=0 immediately. After release, state is IDLE.
- ALU op: regSrc=00, aluOutM=32'h1234, we=1, rd=5 -> next edge Regfile_weW=1, rd=5, data=32'h1234, dmem_req never high.
- Zero-wait load: regSrc=01, aluOutM=32'h103, ack same cycle, rdata=32'hCAFEF00D -> dmem_addr=32'h100, stallM=0, W data=32'hCAFEF00D.
- 3-wait store: DataMem_weM=1, ack after 3 cycles -> stallM high exactly 3 cycles, address/data stable, Regfile_weW stays 0.
- Link: regSrc=10, pcM=32'hFFFFFFFC -> W data=32'h00000000.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): load, no ack -> abort in the 4th WAIT cycle, mem_err pulses once, Regfile_weW=0, next instruction proceeds.
